// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned RegW     = 32;
  localparam int unsigned AluOpW   = 8;
  localparam int unsigned StallW   = 6;
  localparam int unsigned SelW     = 4;
  localparam int unsigned RegAddrW = 5;

  localparam logic NoStop       = 1'b0;
  localparam logic WriteDisable = 1'b0;

  localparam logic [AluOpW-1:0] AluLb  = 8'b1110_0000;
  localparam logic [AluOpW-1:0] AluLbu = 8'b1110_0100;
  localparam logic [AluOpW-1:0] AluLh  = 8'b1110_0001;
  localparam logic [AluOpW-1:0] AluLhu = 8'b1110_0101;
  localparam logic [AluOpW-1:0] AluLw  = 8'b1110_0011;
  localparam logic [AluOpW-1:0] AluSb  = 8'b1110_1000;
  localparam logic [AluOpW-1:0] AluSh  = 8'b1110_1001;
  localparam logic [AluOpW-1:0] AluSw  = 8'b1110_1011;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuReq  = 2'd1,
    LsuDone = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic            req;
    logic            we;
    logic [RegW-1:0] addr;
    logic [SelW-1:0] sel;
    logic [RegW-1:0] wdata;
  } bus_pkt_t;

  function automatic logic is_load(input logic [AluOpW-1:0] op);
    return (op == AluLb) || (op == AluLbu) || (op == AluLh) ||
           (op == AluLhu) || (op == AluLw);
  endfunction

  function automatic logic is_store(input logic [AluOpW-1:0] op);
    return (op == AluSb) || (op == AluSh) || (op == AluSw);
  endfunction

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [AluOpW-1:0] op, input logic [1:0] a);
    return (((op == AluLh) || (op == AluLhu) || (op == AluSh)) && a[0]) ||
           (((op == AluLw) || (op == AluSw)) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Big-endian byte-lane steering: store lanes/data and load extraction/extension.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [AluOpW-1:0] aluop_i,
  input  logic [1:0]        addr_i,
  input  logic [RegW-1:0]   reg2_i,
  input  logic [RegW-1:0]   rdata_i,
  output logic [SelW-1:0]   sel_o,
  output logic [RegW-1:0]   wdata_o,
  output logic [RegW-1:0]   ldata_o
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    lbyte = rdata_i[31:24];
    case (addr_i)
      2'd0: lbyte = rdata_i[31:24];
      2'd1: lbyte = rdata_i[23:16];
      2'd2: lbyte = rdata_i[15:8];
      2'd3: lbyte = rdata_i[7:0];
      default: lbyte = rdata_i[31:24];
    endcase
    lhalf = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    sel_o   = '0;
    wdata_o = '0;
    ldata_o = '0;
    case (aluop_i)
      AluLb:  begin sel_o = 4'hF; ldata_o = {{24{lbyte[7]}}, lbyte}; end
      AluLbu: begin sel_o = 4'hF; ldata_o = {24'h0, lbyte}; end
      AluLh:  begin sel_o = 4'hF; ldata_o = {{16{lhalf[15]}}, lhalf}; end
      AluLhu: begin sel_o = 4'hF; ldata_o = {16'h0, lhalf}; end
      AluLw:  begin sel_o = 4'hF; ldata_o = rdata_i; end
      AluSb: begin
        sel_o   = 4'b1000 >> addr_i;
        wdata_o = {4{reg2_i[7:0]}};
      end
      AluSh: begin
        sel_o   = addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{reg2_i[15:0]}};
      end
      AluSw: begin
        sel_o   = 4'hF;
        wdata_o = reg2_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: single-outstanding req/ack bus access with pipeline stall and timeout.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access suppression and a misalign flag.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallW-1:0]   stall,
  input  logic [AluOpW-1:0]   mem_aluop,
  input  logic [RegW-1:0]     mem_addr,
  input  logic [RegW-1:0]     mem_reg2,
  input  logic [RegAddrW-1:0] mem_wd,
  input  logic                mem_wreg,
  input  logic [RegW-1:0]     mem_wdata,
  input  logic [RegW-1:0]     mem_hi,
  input  logic [RegW-1:0]     mem_lo,
  input  logic                mem_whilo,
  output logic [RegAddrW-1:0] wb_wd,
  output logic                wb_wreg,
  output logic [RegW-1:0]     wb_wdata,
  output logic [RegW-1:0]     wb_hi,
  output logic [RegW-1:0]     wb_lo,
  output logic                wb_whilo,
  output logic                stallreq,
  output logic                bus_req,
  output logic                bus_we,
  output logic [RegW-1:0]     bus_addr,
  output logic [SelW-1:0]     bus_sel,
  output logic [RegW-1:0]     bus_wdata,
  input  logic [RegW-1:0]     bus_rdata,
  input  logic                bus_ack,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                misalign,
`endif
  output logic                bus_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e      state_q, state_d;
  bus_pkt_t        bus_q, bus_d;
  logic [RegW-1:0] rdata_q, rdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`ifdef MEM_ALIGN_CHECK_EN
  logic            mis_q, mis_d;
`endif

  logic            ld_op, st_op, mem_op, misaligned;
  logic [SelW-1:0] al_sel;
  logic [RegW-1:0] al_wdata, al_ldata;
  logic            unused_stall;

  assign ld_op        = is_load(mem_aluop);
  assign st_op        = is_store(mem_aluop);
  assign mem_op       = ld_op | st_op;
  assign unused_stall = ^{stall[StallW-1:5], stall[3:0]};
`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned   = mem_op & is_misaligned(mem_aluop, mem_addr[1:0]);
`else
  assign misaligned   = 1'b0;
`endif

  // Extraction runs off the captured read word; EX/MEM is held stable while stalled.
  mem_lane_align u_align (
    .aluop_i (mem_aluop),
    .addr_i  (mem_addr[1:0]),
    .reg2_i  (mem_reg2),
    .rdata_i (rdata_q),
    .sel_o   (al_sel),
    .wdata_o (al_wdata),
    .ldata_o (al_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LsuIdle;
      bus_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MEM_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    stallreq = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d    = mis_q;
`endif
    case (state_q)
      LsuIdle: begin
        if (mem_op) begin
          stallreq = 1'b1;
          cnt_d    = '0;
          if (misaligned) begin
            state_d = LsuDone;
            rdata_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_d   = 1'b1;
`endif
          end else begin
            state_d     = LsuReq;
            bus_d.req   = 1'b1;
            bus_d.we    = st_op;
            bus_d.addr  = {mem_addr[RegW-1:2], 2'b00};
            bus_d.sel   = al_sel;
            bus_d.wdata = al_wdata;
          end
        end
      end
      LsuReq: begin
        stallreq = 1'b1;
        // Ack takes priority over an abort on the same edge.
        if (bus_ack) begin
          state_d = LsuDone;
          rdata_d = bus_rdata;
          bus_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = LsuDone;
          rdata_d = '0;
          err_d   = 1'b1;
          bus_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      LsuDone: begin
        if (stall[4] == NoStop) begin
          state_d = LsuIdle;
`ifdef MEM_ALIGN_CHECK_EN
          mis_d   = 1'b0;
`endif
        end
      end
      default: state_d = LsuIdle;
    endcase
  end

  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    wb_hi    = mem_hi;
    wb_lo    = mem_lo;
    wb_whilo = mem_whilo;
    if (ld_op) wb_wdata = al_ldata;
    if (st_op || misaligned) wb_wreg = WriteDisable;
  end

  assign bus_req   = bus_q.req;
  assign bus_we    = bus_q.we;
  assign bus_addr  = bus_q.addr;
  assign bus_sel   = bus_q.sel;
  assign bus_wdata = bus_q.wdata;
  assign bus_err   = err_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign  = mis_q;
`endif

endmodule
